// File: rtl/data_memory_bridge.sv
// ============================================================================
// data_memory_bridge : load/store bridge from the core data port to NREG
// synchronous RAM banks (decode, byte lanes, extension, wait states, faults).
// Revision 1.0
// ============================================================================
`default_nettype none

module data_memory_bridge #(
    parameter int                 NREG      = 2,
    parameter logic [NREG*32-1:0] REG_BASE  = {32'h9000_0000, 32'h1001_0000},
    parameter logic [NREG*32-1:0] REG_WORDS = {32'd512, 32'd2048},
    parameter int                 MEM_AW    = 11,
    parameter int                 WAIT      = 0
) (
    input  logic                 iCLK,
    input  logic                 iRST_n,
    input  logic                 iReq,
    input  logic                 iWe,
    input  logic [1:0]           iSize,
    input  logic                 iUnsigned,
    input  logic [31:0]          iAddr,
    input  logic [31:0]          iWData,
    output logic                 oReady,
    output logic [31:0]          oRData,
    output logic                 oFault,
    output logic [31:0]          oFaultAddr,
    output logic [NREG-1:0]      oMemEn,
    output logic                 oMemWe,
    output logic [MEM_AW-1:0]    oMemAddr,
    output logic [3:0]           oMemBE,
    output logic [31:0]          oMemWData,
    input  logic [NREG*32-1:0]   iMemRData
);

    localparam int         c_BW        = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [3:0] c_WAIT_LAST = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_WAITS  = 3'd2,
        S_RESP   = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t            state_q;
    logic              we_q, uns_q, cap_q;
    logic [1:0]        size_q;
    logic [31:0]       addr_q, raw_q;
    logic [c_BW-1:0]   bank_q;
    logic [3:0]        cnt_q;
    logic              ready_q, fault_q, mem_we_q;
    logic [31:0]       rdata_q, fault_addr_q, mem_wdata_q;
    logic [NREG-1:0]   mem_en_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [3:0]        mem_be_q;

    logic              w_hit, w_mis;
    logic [c_BW-1:0]   w_bank;
    logic [MEM_AW-1:0] w_idx;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata, w_bank_rd, w_raw, w_fmt;
    logic [7:0]        w_lane8;
    logic [15:0]       w_lane16;

    // Scan from the top bank down so the lowest-index overlapping bank wins.
    always_comb begin
        w_hit  = 1'b0;
        w_bank = '0;
        w_idx  = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (iAddr >= REG_BASE[i*32 +: 32] &&
                {2'b00, iAddr - REG_BASE[i*32 +: 32]} < {REG_WORDS[i*32 +: 32], 2'b00}) begin
                w_hit  = 1'b1;
                w_bank = c_BW'(i);
                w_idx  = MEM_AW'((iAddr - REG_BASE[i*32 +: 32]) >> 2);
            end
        end
    end

    always_comb begin
        w_mis   = 1'b0;
        w_be    = 4'b1111;
        w_wdata = iWData;
        case (iSize)
            2'd0: begin
                w_be    = 4'b0001 << iAddr[1:0];
                w_wdata = {4{iWData[7:0]}};
            end
            2'd1: begin
                w_mis   = iAddr[0];
                w_be    = iAddr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{iWData[15:0]}};
            end
            2'd2:    w_mis = (iAddr[1:0] != 2'b00);
            default: w_mis = 1'b1;
        endcase
    end

    always_comb begin
        w_bank_rd = '0;
        for (int i = 0; i < NREG; i++) begin
            if (bank_q == c_BW'(i)) w_bank_rd = iMemRData[i*32 +: 32];
        end
    end

    // With no wait states the RAM word is consumed straight off the bus.
    assign w_raw = cap_q ? w_bank_rd : raw_q;

    always_comb begin
        case (addr_q[1:0])
            2'd0:    w_lane8 = w_raw[7:0];
            2'd1:    w_lane8 = w_raw[15:8];
            2'd2:    w_lane8 = w_raw[23:16];
            default: w_lane8 = w_raw[31:24];
        endcase
        w_lane16 = addr_q[1] ? w_raw[31:16] : w_raw[15:0];
        case (size_q)
            2'd0:    w_fmt = uns_q ? {24'd0, w_lane8}  : {{24{w_lane8[7]}}, w_lane8};
            2'd1:    w_fmt = uns_q ? {16'd0, w_lane16} : {{16{w_lane16[15]}}, w_lane16};
            default: w_fmt = w_raw;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            cap_q        <= 1'b0;
            size_q       <= 2'd0;
            addr_q       <= '0;
            raw_q        <= '0;
            bank_q       <= '0;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
            rdata_q      <= '0;
            fault_addr_q <= '0;
            mem_en_q     <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
        end else begin
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            rdata_q     <= '0;
            mem_en_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            cap_q       <= 1'b0;
            if (cap_q) raw_q <= w_bank_rd;
            case (state_q)
                S_IDLE: begin
                    if (iReq) begin
                        we_q   <= iWe;
                        size_q <= iSize;
                        uns_q  <= iUnsigned;
                        addr_q <= iAddr;
                        if (!w_hit || w_mis) begin
                            state_q <= S_FAULT;
                        end else begin
                            state_q     <= S_ACCESS;
                            bank_q      <= w_bank;
                            mem_en_q    <= NREG'(1) << w_bank;
                            mem_we_q    <= iWe;
                            mem_addr_q  <= w_idx;
                            mem_be_q    <= w_be;
                            mem_wdata_q <= w_wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    cap_q   <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= (WAIT > 0) ? S_WAITS : S_RESP;
                end
                S_WAITS: begin
                    if (cnt_q == c_WAIT_LAST) state_q <= S_RESP;
                    else                      cnt_q   <= cnt_q + 4'd1;
                end
                S_RESP: begin
                    ready_q <= 1'b1;
                    rdata_q <= we_q ? 32'd0 : w_fmt;
                    state_q <= S_IDLE;
                end
                S_FAULT: begin
                    ready_q      <= 1'b1;
                    fault_q      <= 1'b1;
                    fault_addr_q <= addr_q;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign oReady     = ready_q;
    assign oRData     = rdata_q;
    assign oFault     = fault_q;
    assign oFaultAddr = fault_addr_q;
    assign oMemEn     = mem_en_q;
    assign oMemWe     = mem_we_q;
    assign oMemAddr   = mem_addr_q;
    assign oMemBE     = mem_be_q;
    assign oMemWData  = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_data_memory_bridge.sv
// ============================================================================
// tb_data_memory_bridge : directed scoreboard bench, WAIT=0 and WAIT=3 copies.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_data_memory_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  req;
    logic        we, uns;
    logic [1:0]  sz;
    logic [31:0] addr, wd;

    logic        rdy0, rdy1, flt0, flt1, mwe0, mwe1;
    logic [31:0] rd0, rd1, fa0, fa1, mwd0, mwd1;
    logic [1:0]  en0, en1;
    logic [10:0] ma0, ma1;
    logic [3:0]  be0, be1;
    logic [63:0] mrd0, mrd1;

    data_memory_bridge #(.WAIT(0)) u_dut0 (
        .iCLK(clk), .iRST_n(rst_n), .iReq(req[0]), .iWe(we), .iSize(sz),
        .iUnsigned(uns), .iAddr(addr), .iWData(wd), .oReady(rdy0), .oRData(rd0),
        .oFault(flt0), .oFaultAddr(fa0), .oMemEn(en0), .oMemWe(mwe0),
        .oMemAddr(ma0), .oMemBE(be0), .oMemWData(mwd0), .iMemRData(mrd0));

    data_memory_bridge #(.WAIT(3)) u_dut1 (
        .iCLK(clk), .iRST_n(rst_n), .iReq(req[1]), .iWe(we), .iSize(sz),
        .iUnsigned(uns), .iAddr(addr), .iWData(wd), .oReady(rdy1), .oRData(rd1),
        .oFault(flt1), .oFaultAddr(fa1), .oMemEn(en1), .oMemWe(mwe1),
        .oMemAddr(ma1), .oMemBE(be1), .oMemWData(mwd1), .iMemRData(mrd1));

    // Registered RAM banks, one pair per bridge instance.
    logic [31:0] mem0 [2][2048];
    logic [31:0] mem1 [2][2048];

    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (en0[b]) begin
                if (mwe0) for (int k = 0; k < 4; k++) if (be0[k]) mem0[b][ma0][k*8 +: 8] <= mwd0[k*8 +: 8];
                mrd0[b*32 +: 32] <= mem0[b][ma0];
            end
            if (en1[b]) begin
                if (mwe1) for (int k = 0; k < 4; k++) if (be1[k]) mem1[b][ma1][k*8 +: 8] <= mwd1[k*8 +: 8];
                mrd1[b*32 +: 32] <= mem1[b][ma1];
            end
        end
    end

    typedef struct {
        logic        f;
        logic [31:0] d;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    int nvec = 0;
    int nfail = 0;

    logic [1:0]  seen_en;
    logic        seen_we;
    logic [10:0] seen_ma;
    logic [3:0]  seen_be;
    logic [31:0] seen_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sample_mem(input int inst);
        logic [1:0] e;
        e = (inst == 0) ? en0 : en1;
        if (e != 2'b00) begin
            seen_en = seen_en | e;
            seen_we = (inst == 0) ? mwe0 : mwe1;
            seen_ma = (inst == 0) ? ma0  : ma1;
            seen_be = (inst == 0) ? be0  : be1;
            seen_wd = (inst == 0) ? mwd0 : mwd1;
        end
    endtask

    task automatic access(input int inst, input logic [31:0] a, input logic w,
                          input logic [1:0] s, input logic u, input logic [31:0] d,
                          input logic ef, input logic [31:0] er, input int el,
                          input bit poke);
        int   lat;
        int   extra;
        exp_t e;
        sb_q.push_back('{ef, er, el});
        seen_en = '0; seen_we = 1'b0; seen_ma = '0; seen_be = '0; seen_wd = '0;
        @(negedge clk);
        addr = a; we = w; sz = s; uns = u; wd = d;
        req[inst] = 1'b1;
        @(negedge clk);
        req  = '0;
        addr = 32'h0000_0004;
        wd   = 32'h0;
        lat  = 0;
        while (lat < 30) begin
            sample_mem(inst);
            if (((inst == 0) ? rdy0 : rdy1) === 1'b1) break;
            @(negedge clk);
            lat++;
            req[inst] = poke && (lat == 1 || lat == 2);
        end
        req = '0;
        e = sb_q.pop_front();
        chk("ready_seen", {31'd0, lat < 30}, 32'd1);
        chk("latency", lat, e.lat);
        chk("fault", {31'd0, (inst == 0) ? flt0 : flt1}, {31'd0, e.f});
        chk("rdata", (inst == 0) ? rd0 : rd1, e.d);
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            sample_mem(inst);
            if (((inst == 0) ? rdy0 : rdy1) !== 1'b0) extra++;
        end
        chk("no_extra_ready", extra, 0);
    endtask

    initial begin
        int bad;
        rst_n = 1'b0; req = '0; we = 1'b0; uns = 1'b0; sz = 2'd0; addr = '0; wd = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, rdy0}, 32'd0);
        chk("rst_rdata", rd0, 32'd0);
        chk("rst_faddr", fa0, 32'd0);
        chk("rst_en", {30'd0, en0}, 32'd0);
        chk("rst_be", {28'd0, be1}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Word store then load back, bank 0.
        access(0, 32'h1001_0008, 1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, 1'b0);
        chk("st_en", {30'd0, seen_en}, 32'h1);
        chk("st_we", {31'd0, seen_we}, 32'h1);
        chk("st_addr", {21'd0, seen_ma}, 32'd2);
        chk("st_be", {28'd0, seen_be}, 32'hF);
        chk("st_wd", seen_wd, 32'hDEAD_BEEF);
        access(0, 32'h1001_0008, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 1'b0);
        chk("ld_en", {30'd0, seen_en}, 32'h1);
        chk("ld_we", {31'd0, seen_we}, 32'h0);

        // Byte and half loads with extension.
        access(0, 32'h1001_0009, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFBE, 2, 1'b0);
        chk("lb_be", {28'd0, seen_be}, 32'h2);
        access(0, 32'h1001_0009, 1'b0, 2'd0, 1'b1, 32'h0, 1'b0, 32'h0000_00BE, 2, 1'b0);
        access(0, 32'h1001_000B, 1'b0, 2'd0, 1'b1, 32'h0, 1'b0, 32'h0000_00DE, 2, 1'b0);
        access(0, 32'h1001_0008, 1'b0, 2'd1, 1'b0, 32'h0, 1'b0, 32'hFFFF_BEEF, 2, 1'b0);
        access(0, 32'h1001_000A, 1'b0, 2'd1, 1'b1, 32'h0, 1'b0, 32'h0000_DEAD, 2, 1'b0);

        // Half store into bank 1 and read back.
        access(0, 32'h9000_0002, 1'b1, 2'd1, 1'b0, 32'h5555_1234, 1'b0, 32'h0, 2, 1'b0);
        chk("sh_en", {30'd0, seen_en}, 32'h2);
        chk("sh_be", {28'd0, seen_be}, 32'hC);
        chk("sh_wd", seen_wd, 32'h1234_1234);
        chk("sh_addr", {21'd0, seen_ma}, 32'd0);
        access(0, 32'h9000_0002, 1'b0, 2'd1, 1'b0, 32'h0, 1'b0, 32'h0000_1234, 2, 1'b0);

        // Bank boundaries.
        access(0, 32'h1001_1FFC, 1'b1, 2'd0, 1'b0, 32'h0000_00A5, 1'b0, 32'h0, 2, 1'b0);
        chk("top_addr", {21'd0, seen_ma}, 32'd2047);
        chk("top_be", {28'd0, seen_be}, 32'h1);
        access(0, 32'h1001_1FFC, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFA5, 2, 1'b0);
        access(0, 32'h1001_2000, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 32'h0, 1, 1'b0);
        chk("past_end_en", {30'd0, seen_en}, 32'h0);
        access(0, 32'h9000_0800, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 32'h0, 1, 1'b0);
        chk("faddr_b1end", fa0, 32'h9000_0800);

        // Unmapped, misaligned and illegal-size faults.
        access(0, 32'h0000_0000, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 32'h0, 1, 1'b0);
        chk("unmap_en", {30'd0, seen_en}, 32'h0);
        chk("faddr_unmap", fa0, 32'h0000_0000);
        access(0, 32'h1001_0001, 1'b0, 2'd1, 1'b0, 32'h0, 1'b1, 32'h0, 1, 1'b0);
        chk("mis_en", {30'd0, seen_en}, 32'h0);
        chk("faddr_mis", fa0, 32'h1001_0001);
        access(0, 32'h1001_0006, 1'b1, 2'd2, 1'b0, 32'h1111_1111, 1'b1, 32'h0, 1, 1'b0);
        access(0, 32'h1001_0000, 1'b0, 2'd3, 1'b0, 32'h0, 1'b1, 32'h0, 1, 1'b0);
        chk("faddr_sz3", fa0, 32'h1001_0000);

        // Wait-state instance with requests poked while busy.
        access(1, 32'h1001_0010, 1'b1, 2'd2, 1'b0, 32'hCAFE_F00D, 1'b0, 32'h0, 5, 1'b1);
        chk("w3_st_addr", {21'd0, seen_ma}, 32'd4);
        access(1, 32'h1001_0010, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0, 32'hCAFE_F00D, 5, 1'b1);
        access(1, 32'h1001_0012, 1'b0, 2'd1, 1'b0, 32'h0, 1'b0, 32'hFFFF_CAFE, 5, 1'b0);
        chk("w3_faddr", fa1, 32'h0);

        // Reset while ACCESS is active.
        @(negedge clk);
        addr = 32'h1001_0008; we = 1'b0; sz = 2'd2; uns = 1'b0; req[0] = 1'b1;
        @(negedge clk);
        req = '0;
        chk("pre_rst_en", {30'd0, en0}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_en", {30'd0, en0}, 32'h0);
        chk("rst_mid_ready", {31'd0, rdy0}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (rdy0 !== 1'b0 || en0 !== 2'b00) bad++;
        end
        chk("rst_abort_quiet", bad, 0);
        access(0, 32'h1001_0008, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

`default_nettype wire
